// File: rtl/rf_wr_port_arbiter_if.sv
// Request/grant bundle between the execution units and the register-file write-port arbiter.
interface rf_wr_port_arbiter_if #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
);
   logic [N-1:0]   req;
   logic [N-1:0]   done;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [IDW-1:0] gnt_id;
   logic           timeout;

   modport master (
      output req, done,
      input  gnt, gnt_valid, gnt_id, timeout
   );

   modport slave (
      input  req, done,
      output gnt, gnt_valid, gnt_id, timeout
   );
endinterface

// File: rtl/rf_wr_port_arbiter.sv
// Round-robin arbiter for the shared register-file write port, with a bounded hold time
// and back-to-back re-arbitration on release.
//
//   state | meaning
//   IDLE  | no grant outstanding; arbitrate from ptr on every edge
//   GRANT | gnt_id_q owns the port; release on req drop, done, or hold limit
module rf_wr_port_arbiter #(
   parameter int N        = 4,
   parameter int HOLD_MAX = 8,
   parameter int IDW      = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  reset,
   rf_wr_port_arbiter_if.slave   arb_io
);

   localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic           gnt_valid_q, gnt_valid_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic           timeout_q, timeout_d;

   logic           rel;
   logic           arb;
   logic [IDW-1:0] base;
   logic [IDW-1:0] g;
   logic           found;
   logic [IDW-1:0] pick_idx;

   // First requester at or after base, wrapping modulo N.
   always_comb begin
      found    = 1'b0;
      pick_idx = '0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (int'(base) + k) % N;
         if (!found && arb_io.req[j[IDW-1:0]]) begin
            found    = 1'b1;
            pick_idx = j[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_id_d    = gnt_id_q;
      timeout_d   = 1'b0;
      rel         = 1'b0;
      arb         = 1'b0;
      g           = gnt_id_q;
      base        = ptr_q;

      case (state_q)
         IDLE: arb = 1'b1;
         GRANT: begin
            if (!arb_io.req[g] || arb_io.done[g]) begin
               rel = 1'b1;
            end else if (hold_q == HW'(HOLD_MAX - 1)) begin
               rel       = 1'b1;
               timeout_d = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: arb = 1'b1;
      endcase

      // The released index drops to lowest priority before the same-edge re-arbitration.
      if (rel) begin
         ptr_d = (g == IDW'(N - 1)) ? '0 : g + 1'b1;
         base  = ptr_d;
         arb   = 1'b1;
      end

      if (arb) begin
         hold_d = '0;
         gnt_d  = '0;
         if (found) begin
            gnt_d[pick_idx] = 1'b1;
            gnt_id_d        = pick_idx;
            gnt_valid_d     = 1'b1;
            state_d         = GRANT;
         end else begin
            gnt_valid_d = 1'b0;
            state_d     = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         hold_q      <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         timeout_q   <= timeout_d;
      end
   end

   assign arb_io.gnt       = gnt_q;
   assign arb_io.gnt_valid = gnt_valid_q;
   assign arb_io.gnt_id    = gnt_id_q;
   assign arb_io.timeout   = timeout_q;

endmodule

// File: tb/tb_rf_wr_port_arbiter.sv
// Directed bench for rf_wr_port_arbiter: an integer-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_rf_wr_port_arbiter;
   localparam int N        = 4;
   localparam int HOLD_MAX = 8;
   localparam int IDW      = 2;

   logic clk;
   logic rst_b;
   int   checks;
   int   failures;

   rf_wr_port_arbiter_if #(.N(N), .IDW(IDW)) bus ();

   rf_wr_port_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX), .IDW(IDW)) dut (
      .clk    (clk),
      .reset  (rst_b),
      .arb_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: cur = owner index (-1 idle), held = cycles owned so far, mptr = priority start.
   int cur, held, mptr, last_id;
   bit mto;

   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cur = -1; held = 0; mptr = 0; last_id = 0; mto = 0;
      end else begin
         bit rel;
         int b;
         rel = 0; mto = 0; b = mptr;
         if (cur >= 0) begin
            if (!bus.req[cur] || bus.done[cur]) rel = 1;
            else if (held == HOLD_MAX) begin rel = 1; mto = 1; end
            else held++;
            if (rel) begin
               mptr = (cur + 1) % N;
               b    = mptr;
               cur  = -1;
            end
         end
         if (cur < 0) begin
            for (int k = 0; k < N; k++)
               if (cur < 0 && bus.req[(b + k) % N]) cur = (b + k) % N;
            if (cur >= 0) begin
               held    = 1;
               last_id = cur;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] e;
      e = '0;
      if (cur >= 0) e[cur] = 1'b1;
      chk("model_gnt", 32'(bus.gnt), 32'(e));
      chk("model_gnt_valid", 32'(bus.gnt_valid), 32'(cur >= 0));
      chk("model_gnt_id", 32'(bus.gnt_id), 32'(last_id));
      chk("model_timeout", 32'(bus.timeout), 32'(mto));
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int cnt;
      checks = 0; failures = 0;
      rst_b = 1'b0;
      bus.req = '0;
      bus.done = '0;

      // Reset mid-grant
      @(negedge clk);
      rst_b = 1'b1;
      bus.req = 4'b0010;
      step(1);
      chk("rst_pre_gnt", 32'(bus.gnt), 32'h2);
      #2 rst_b = 1'b0;
      #1;
      chk("rst_async_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_async_valid", 32'(bus.gnt_valid), 32'h0);
      chk("rst_async_timeout", 32'(bus.timeout), 32'h0);
      chk("rst_async_id", 32'(bus.gnt_id), 32'h0);
      step(1);
      rst_b = 1'b1;
      step(1);
      chk("rst_regrant", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      step(1);
      chk("idle_gnt", 32'(bus.gnt), 32'h0);

      // Single requester with done in its 3rd cycle (ptr=2)
      bus.req = 4'b0100;
      step(1);
      chk("single_c1", 32'(bus.gnt), 32'h4);
      step(1);
      chk("single_c2", 32'(bus.gnt), 32'h4);
      step(1);
      chk("single_c3", 32'(bus.gnt), 32'h4);
      bus.done = 4'b0100;
      step(1);
      bus.done = '0;
      chk("single_regrant", 32'(bus.gnt), 32'h4);
      chk("single_id", 32'(bus.gnt_id), 32'h2);
      chk("single_no_to", 32'(bus.timeout), 32'h0);
      bus.req = '0;
      step(1);

      // Wrap-around: ptr=3, req=0101 -> index 0
      bus.req = 4'b0101;
      step(1);
      chk("wrap_gnt", 32'(bus.gnt), 32'h1);
      chk("wrap_id", 32'(bus.gnt_id), 32'h0);
      bus.req = '0;
      step(1);

      // Spurious done on non-granted index, then dropped request
      bus.req = 4'b0010;
      step(1);
      chk("spur_gnt", 32'(bus.gnt), 32'h2);
      bus.done = 4'b0001;
      step(1);
      chk("spur_hold", 32'(bus.gnt), 32'h2);
      bus.done = '0;
      bus.req = 4'b1000;
      step(1);
      chk("drop_gnt", 32'(bus.gnt), 32'h8);
      chk("drop_id", 32'(bus.gnt_id), 32'h3);
      bus.req = '0;
      step(1);

      // Round-robin fairness from ptr=0
      bus.req  = 4'b1111;
      bus.done = 4'b1111;
      step(1);
      for (int k = 0; k < 6; k++) begin
         chk("rr_id", 32'(bus.gnt_id), 32'(k % 4));
         chk("rr_gnt", 32'(bus.gnt), 32'(1 << (k % 4)));
         chk("rr_valid", 32'(bus.gnt_valid), 32'h1);
         step(1);
      end
      bus.req  = '0;
      bus.done = '0;
      step(1);

      // Timeout: ptr=3, req=0011 -> 0 holds HOLD_MAX cycles
      bus.req = 4'b0011;
      step(1);
      cnt = 0;
      while (bus.gnt == 4'b0001 && cnt < 20) begin
         cnt++;
         step(1);
      end
      chk("to_hold_cycles", 32'(cnt), 32'(HOLD_MAX));
      chk("to_pulse", 32'(bus.timeout), 32'h1);
      chk("to_next_gnt", 32'(bus.gnt), 32'h2);
      step(1);
      chk("to_pulse_end", 32'(bus.timeout), 32'h0);
      chk("to_hold2", 32'(bus.gnt), 32'h2);

      // done at the HOLD_MAX boundary releases without timeout
      step(HOLD_MAX - 2);
      chk("bnd_still", 32'(bus.gnt), 32'h2);
      bus.done = 4'b0010;
      step(1);
      bus.done = '0;
      chk("bnd_no_to", 32'(bus.timeout), 32'h0);
      chk("bnd_next", 32'(bus.gnt), 32'h1);
      bus.req = '0;
      step(2);
      chk("end_idle", 32'(bus.gnt_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected bench completion");
      $fatal(1);
   end
endmodule

// File: doc/rf_wr_port_arbiter.md
Name: rf_wr_port_arbiter

Overview:
- Round-robin arbiter that shares the single register-file write port, built from our 1-bit flip-flop cells, among N requesters such as ALU writeback, load unit and CSR/move path.
- Issues one-hot registered grants with a request/done handshake.
- Forces release after a bounded hold time so one requester cannot starve the others.
- Sits between the execution units and the register-file write-enable/select mux.

Parameters:
- N, 4, number of requesters (N >= 2).
- HOLD_MAX, 8, maximum consecutive cycles a single grant may be held (HOLD_MAX >= 1).
- IDW, $clog2(N), width of gnt_id.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  N  per-requester write request, level, held until granted.
- done  input  N  per-requester completion strobe; sampled only for the granted index.
- gnt  output  N  one-hot grant, registered; all-zero when idle.
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  IDW  binary index of granted requester; holds last value when idle.
- timeout  output  1  one-cycle pulse when a grant is force-released at HOLD_MAX.

Behaviour:
- Reset: reset and clk are as decided above (reset asynchronous, active-low; clock clk).
  - While reset==0: gnt=0, gnt_valid=0, gnt_id=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
  - Reset takes effect immediately, independent of clk. A grant in progress is dropped without a timeout pulse.
- State IDLE: if req != 0, select the first index i with req[i]=1 scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - On the next edge: gnt[i]=1, gnt_id=i, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req rising to gnt is 1 cycle. If req==0, stay IDLE with outputs at 0.
- State GRANT, granted index g: each edge evaluates the release conditions, in priority order:
  - (a) req[g]==0: release, no timeout.
  - (b) done[g]==1: release, no timeout.
  - (c) hold_cnt==HOLD_MAX-1: release, timeout=1 for exactly the next cycle.
  - Otherwise hold_cnt increments and the grant holds.
  - The grant is therefore high for at most HOLD_MAX cycles.
- On release: ptr <= (g+1) mod N, so g becomes lowest priority.
  - Same edge: re-arbitrate over current req using the updated ptr.
  - If any req is set (including g itself when it is the sole requester), the new grant appears on that edge. Back-to-back grants have no bubble, and gnt changes one-hot to one-hot directly.
  - If req==0 after release: gnt=0, gnt_valid=0, state=IDLE.
- Pointer update: ptr changes only on release, never on the initial grant from IDLE.
- done handling: done bits of non-granted indices are ignored. A done that coincides with the HOLD_MAX boundary counts as a normal release, with no timeout.
- Invariants: gnt is always one-hot or zero. gnt_valid==|gnt. When gnt_valid=1, gnt_id==index of gnt. gnt never asserts for an index whose req was 0 on the arbitration edge.
- Wrap-around: the scan wraps modulo N, and ptr wraps from N-1 to 0.
- Outputs are all registered, with no combinational path from req or done to gnt.

Test Plan:
- Reset mid-grant: req=0010, grant active, then reset=0 asynchronously between edges -> gnt=0000, gnt_valid=0, timeout=0 immediately. After release with req=0010, gnt=0010 one edge later.
- Single requester with done: req=0100, done[2] pulsed in the 3rd grant cycle -> gnt=0100 for 3 cycles, then gnt=0100 again on the next edge (sole requester, ptr=3), gnt_id=2.
- Round-robin fairness: req=1111 held, each grantee pulses done in its 1st grant cycle -> grant order 0,1,2,3,0,1 with no idle cycles and gnt_id sequence 0,1,2,3,0,1.
- Timeout: HOLD_MAX=8, req=0011, requester 0 never asserts done -> gnt=0001 for exactly 8 cycles, timeout=1 for one cycle, gnt=0010 from the same edge.
- Spurious done and dropped request: granted index 1, done=0001 asserted -> no release. Then req[1] deasserted with req=1000 -> gnt=1000 next edge, ptr=2.
- Wrap-around: ptr=3 (after a release of index 2), req=0101 -> index 0 granted, not index 2.
